instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/sequence stage directly upstream of the microcode control memory in the xupt181 4-bit CPU.
- Fetches 8-bit instructions {op, n} from program memory and holds them in an instruction register.
- Generates the 2-bit micro-step counter cnt (0..3) per instruction and drives op/cnt into the control memory.
- Consumes the jump bits f[15:14] of the returned control word, with the zero/carry flags and Acc, to perform jumps to 16*n + Acc.

Parameters:
- ADDR_W, 8, program-counter / instruction-memory address width; jump target is {n, acc}, so it must equal 8.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  level: 1 = execute instructions back-to-back.
- step  input  1  single-cycle pulse: execute exactly one instruction while idle.
- hold  input  1  freeze all sequencer state (I/O wait); outputs hold their values.
- imem_data  input  8  program memory read data, combinational for imem_addr.
- f  input  16  control word from control memory; only f[15:14] are used.
- zero_flag  input  1  datapath zero flag.
- carry_flag  input  1  datapath carry flag.
- acc  input  4  current accumulator value.
- imem_addr  output  8  program memory address; equals pc.
- op  output  4  opcode to control memory.
- cnt  output  2  micro-step to control memory.
- n  output  4  operand field to datapath.
- pc  output  8  program counter.
- busy  output  1  1 while in FETCH or EXEC.
- instr_done  output  1  one-cycle pulse when an instruction's cnt=3 cycle completes.

Behaviour:
- Reset (rst=0, async) gives:
  - state=IDLE, pc=RESET_PC, ir=8'h00, cnt=0, busy=0, instr_done=0.
  - op/n are forced to 0 outside EXEC. op=0, cnt=0 selects an inert control word.
- States and transitions:
  - IDLE → FETCH when run=1, or when step=1 (step latches a one-shot flag).
  - FETCH (1 cycle): ir<=imem_data, pc<=pc+1, cnt<=0, then → EXEC.
  - EXEC: op=ir[7:4], n=ir[3:0], cnt increments by 1 each cycle.
- Jump evaluation happens on the cnt=1 edge:
  - f[15]&f[14]: jump unconditionally.
  - f[14] only: jump if zero_flag=1.
  - f[15] only: jump if carry_flag=1.
  - When taken, pc<={n, acc}, overriding the earlier increment. Flags and acc are sampled at that edge.
- cnt=3 edge:
  - instr_done=1 for the following cycle.
  - If run=1 and no step one-shot is pending: ir<=imem_data, pc<=pc+1, cnt<=0, stay in EXEC (no bubble; 4 cycles per instruction).
  - Otherwise → IDLE; the step one-shot is cleared.
- hold=1 in any state freezes pc, ir, cnt, state and the one-shot. instr_done is 0 while held. hold has priority over run, step and jump.
- step while busy is ignored. run and step together in IDLE are treated as run.
- pc wraps 8'hFF → 8'h00 on increment.
- Latency: from run rising in IDLE, first EXEC cnt=0 appears 2 cycles later (IDLE→FETCH→EXEC).
- Reset mid-instruction aborts immediately; no partial jump is retained.
- Registered outputs are updated with #`FFD delay.

Decomposition:
- define.v additions:
  - state encodings S_IDLE=2'd0, S_FETCH=2'd1, S_EXEC=2'd2.
  - control-word bit indices F_JMP_C=15, F_JMP_Z=14.
- No sub-module: PC, instruction register, counter and FSM share one always block set, roughly 150 RTL lines.

Test Plan:
- Run from reset, imem[0]=8'h13, imem[1]=8'h27 → op/cnt sequence 1/0,1/1,1/2,1/3, then 2/0..2/3. pc 1→2. instr_done pulses after each cnt=3.
- Unconditional jump: imem[0]=8'h02, acc=4'h5, f[15:14]=2'b11 at cnt=1 → next op fetched from imem_addr 8'h25.
- Conditional jumps: imem[0]=8'hC3 with zero_flag=0 → next fetch from 8'h01. Repeat with zero_flag=1, acc=4'h4 → fetch from 8'h34. Carry case with 8'hD3 likewise.
- Step mode: run=0, single step pulse → exactly one instruction (cnt 0..3), busy drops, pc=1. A second step while busy has no effect.
- hold=1 asserted for 3 cycles at cnt=2 → cnt stays 2, pc and op unchanged. Sequence resumes at cnt=3 after release.
- Reset asserted at cnt=1 with jump pending → pc=8'h00, cnt=0, busy=0 immediately (asynchronously); no jump after release.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the xupt181 fetch/sequence stage.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } seq_state_e;

    // Jump-control bit positions inside the microcode control word.
    localparam int F_JMP_C = 15;
    localparam int F_JMP_Z = 14;

    // Both bits set: unconditional; a single bit selects its flag.
    function automatic logic jump_taken(input logic jmp_c, input logic jmp_z,
                                        input logic zero_flag, input logic carry_flag);
        return (jmp_c & jmp_z)
             | (jmp_z & ~jmp_c & zero_flag)
             | (jmp_c & ~jmp_z & carry_flag);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer (master) and program memory, control memory and datapath (slave).
interface instr_sequencer_if;

    logic [7:0]  imem_addr;
    logic [7:0]  imem_data;
    logic [3:0]  op;
    logic [1:0]  cnt;
    logic [3:0]  n;
    logic [15:0] f;
    logic        zero_flag;
    logic        carry_flag;
    logic [3:0]  acc;

    modport master (
        output imem_addr, op, cnt, n,
        input  imem_data, f, zero_flag, carry_flag, acc
    );

    modport slave (
        input  imem_addr, op, cnt, n,
        output imem_data, f, zero_flag, carry_flag, acc
    );

endinterface

// File: rtl/instr_sequencer.sv
// Fetch/sequence stage: fetches {op, n}, steps cnt 0..3 per instruction and
// performs jumps to {n, acc} on the cnt=1 edge as directed by f[15:14].
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              hold,
    instr_sequencer_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              instr_done
);

    seq_state_e state;
    logic [7:0] ir;
    logic [1:0] cnt;
    logic       step_pend;
    logic       unused_f;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            cnt        <= '0;
            step_pend  <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            // NOTE: default-low first so instr_done is a single-cycle pulse and is 0 while held.
            instr_done <= 1'b0;
            if (!hold) begin
                unique case (state)
                    S_IDLE: begin
                        if (run) begin
                            state <= S_FETCH;
                        end else if (step) begin
                            state     <= S_FETCH;
                            step_pend <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        ir    <= bus.imem_data;
                        pc    <= pc + ADDR_W'(1);
                        cnt   <= '0;
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd1 &&
                            jump_taken(bus.f[F_JMP_C], bus.f[F_JMP_Z], bus.zero_flag, bus.carry_flag))
                            pc <= {ir[3:0], bus.acc};
                        if (cnt == 2'd3) begin
                            instr_done <= 1'b1;
                            cnt        <= '0;
                            // Back-to-back fetch keeps the pipeline at 4 cycles per instruction.
                            if (run && !step_pend) begin
                                ir <= bus.imem_data;
                                pc <= pc + ADDR_W'(1);
                            end else begin
                                state     <= S_IDLE;
                                step_pend <= 1'b0;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // op/n are zero outside EXEC so op=0, cnt=0 addresses the inert control word.
    assign bus.op        = (state == S_EXEC) ? ir[7:4] : 4'h0;
    assign bus.n         = (state == S_EXEC) ? ir[3:0] : 4'h0;
    assign bus.cnt       = cnt;
    assign bus.imem_addr = pc;
    assign busy          = (state != S_IDLE);
    assign unused_f      = ^bus.f[F_JMP_Z-1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random programs
// checked against an instruction-level model of the fetch/jump rules.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] pc;
    logic       busy;
    logic       instr_done;

    logic [7:0]  imem [256];
    logic [1:0]  jmp_tab [16];
    logic [3:0]  acc = 4'h0;
    logic        zero = 1'b0;
    logic        carry = 1'b0;
    logic [15:0] noise = 16'h0;

    int total = 0;
    int bad   = 0;

    instr_sequencer_if bus ();

    // Program memory and a control memory whose jump bits matter only at cnt=1.
    assign bus.imem_data  = imem[bus.imem_addr];
    assign bus.f          = {(bus.cnt == 2'd1) ? jmp_tab[bus.op] : noise[15:14], noise[13:0]};
    assign bus.acc        = acc;
    assign bus.zero_flag  = zero;
    assign bus.carry_flag = carry;

    instr_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .hold       (hold),
        .bus        (bus),
        .pc         (pc),
        .busy       (busy),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe();
        return {4'h0, bus.op, bus.n, bus.cnt, pc, bus.imem_addr, busy, instr_done};
    endfunction

    function automatic logic [31:0] expect_v(input logic [3:0] op, input logic [3:0] n,
                                             input logic [1:0] cnt, input logic [7:0] p,
                                             input logic bsy, input logic done);
        return {4'h0, op, n, cnt, p, p, bsy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rnd, input logic [3:0] a, input logic z, input logic c);
        noise = 16'($urandom);
        if (rnd) begin
            acc   = 4'($urandom);
            zero  = 1'($urandom);
            carry = 1'($urandom);
        end else begin
            acc   = a;
            zero  = z;
            carry = c;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 16; i++) jmp_tab[i] = 2'b00;
    endtask

    task automatic do_reset();
        run  = 1'b0;
        step = 1'b0;
        hold = 1'b0;
        rst  = 1'b0;
        #2;
        check("reset", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Instruction-level model: each instruction is fetched from the current
    // address, pc is address+1, and a jump decided at the second micro-step
    // redirects the next fetch to {n, acc}.
    task automatic run_seq(input logic [7:0] start_pc, input int n_instr, input logic rnd,
                           input logic [3:0] a, input logic z, input logic c);
        logic [7:0] fa, nxt, ins;
        logic [1:0] jb;
        logic       taken;
        fa  = start_pc;
        run = 1'b1;
        drive(rnd, a, z, c);
        tick();
        check("fetch", observe(), expect_v(4'h0, 4'h0, 2'd0, fa, 1'b1, 1'b0));
        drive(rnd, a, z, c);
        tick();
        for (int k = 0; k < n_instr; k++) begin
            ins = imem[fa];
            nxt = fa + 8'd1;
            for (int s = 0; s < 4; s++) begin
                check("exec", observe(),
                      expect_v(ins[7:4], ins[3:0], 2'(s), (s < 2) ? fa + 8'd1 : nxt,
                               1'b1, (s == 0) && (k > 0)));
                drive(rnd, a, z, c);
                if (s == 1) begin
                    jb    = jmp_tab[ins[7:4]];
                    taken = (jb == 2'b11) || (jb == 2'b01 && zero) || (jb == 2'b10 && carry);
                    if (taken) nxt = {ins[3:0], acc};
                end
                if (s == 3 && k == n_instr - 1) run = 1'b0;
                tick();
            end
            fa = nxt;
        end
        check("idle", observe(), expect_v(4'h0, 4'h0, 2'd0, fa, 1'b0, 1'b1));
    endtask

    initial begin
        clear_mem();

        // Plain back-to-back execution, pc 1 -> 2.
        do_reset();
        imem[0] = 8'h13;
        imem[1] = 8'h27;
        run_seq(8'h00, 2, 1'b0, 4'h0, 1'b0, 1'b0);

        // Unconditional jump to {2, 5}.
        clear_mem();
        do_reset();
        imem[0]    = 8'h02;
        jmp_tab[0] = 2'b11;
        imem[8'h25] = 8'h9A;
        run_seq(8'h00, 2, 1'b0, 4'h5, 1'b0, 1'b0);

        // Zero-conditional jump, not taken then taken.
        clear_mem();
        imem[0]     = 8'hC3;
        jmp_tab[12] = 2'b01;
        imem[1]     = 8'h50;
        imem[8'h34] = 8'h61;
        do_reset();
        run_seq(8'h00, 2, 1'b0, 4'h4, 1'b0, 1'b1);
        do_reset();
        run_seq(8'h00, 2, 1'b0, 4'h4, 1'b1, 1'b0);

        // Carry-conditional jump: ignores zero, follows carry.
        imem[0]     = 8'hD3;
        jmp_tab[13] = 2'b10;
        do_reset();
        run_seq(8'h00, 2, 1'b0, 4'h4, 1'b1, 1'b0);
        do_reset();
        run_seq(8'h00, 2, 1'b0, 4'h4, 1'b0, 1'b1);

        // Jump to 8'hFF, then pc wraps to 8'h00 on the fetch increment.
        clear_mem();
        imem[0]     = 8'h1F;
        jmp_tab[1]  = 2'b11;
        imem[8'hFF] = 8'h70;
        do_reset();
        run_seq(8'h00, 2, 1'b0, 4'hF, 1'b0, 1'b0);

        // Single step; a second step while busy and run rising mid-step are ignored.
        clear_mem();
        imem[0] = 8'h45;
        imem[1] = 8'h88;
        do_reset();
        step = 1'b1;
        tick();
        check("step_fetch", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h00, 1'b1, 1'b0));
        step = 1'b0;
        tick();
        check("step_c0", observe(), expect_v(4'h4, 4'h5, 2'd0, 8'h01, 1'b1, 1'b0));
        step = 1'b1;
        tick();
        check("step_c1", observe(), expect_v(4'h4, 4'h5, 2'd1, 8'h01, 1'b1, 1'b0));
        step = 1'b0;
        tick();
        check("step_c2", observe(), expect_v(4'h4, 4'h5, 2'd2, 8'h01, 1'b1, 1'b0));
        run = 1'b1;
        tick();
        check("step_c3", observe(), expect_v(4'h4, 4'h5, 2'd3, 8'h01, 1'b1, 1'b0));
        tick();
        check("step_end", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h01, 1'b0, 1'b1));
        run = 1'b0;
        tick();
        check("step_idle1", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h01, 1'b0, 1'b0));
        tick();
        check("step_idle2", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h01, 1'b0, 1'b0));

        // Hold for three cycles at cnt=2, then resume at cnt=3.
        clear_mem();
        imem[0] = 8'h13;
        imem[1] = 8'h27;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("pre_hold", observe(), expect_v(4'h1, 4'h3, 2'd2, 8'h01, 1'b1, 1'b0));
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", observe(), expect_v(4'h1, 4'h3, 2'd2, 8'h01, 1'b1, 1'b0));
        end
        hold = 1'b0;
        tick();
        check("resume_c3", observe(), expect_v(4'h1, 4'h3, 2'd3, 8'h01, 1'b1, 1'b0));
        run = 1'b0;
        tick();
        check("resume_end", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h01, 1'b0, 1'b1));
        hold = 1'b1;
        run  = 1'b1;
        tick();
        check("hold_idle", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h01, 1'b0, 1'b0));
        hold = 1'b0;
        run  = 1'b0;

        // Asynchronous reset at cnt=1 with an unconditional jump pending.
        clear_mem();
        imem[0]    = 8'h02;
        jmp_tab[0] = 2'b11;
        do_reset();
        acc = 4'h5;
        run = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst", observe(), expect_v(4'h0, 4'h2, 2'd1, 8'h01, 1'b1, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0));
        tick();
        check("rst_held", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0));
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("post_rst", observe(), expect_v(4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0));

        // Random programs, control words and flag/acc values.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) jmp_tab[i] = 2'($urandom);
            do_reset();
            run_seq(8'h00, 50, 1'b1, 4'h0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
